// File: rtl/hazard_scoreboard.sv
// Hazard scoreboard for a five-stage pipeline with a multi-cycle mult/div unit.
// It produces forwarding selects for the D and E stages. It raises a single
// stall/flush when a load-use, branch-operand or mult/div hazard is seen in
// decode. It also keeps a saturating stall counter and the cause of the last stall.
module hazard_scoreboard #(
  parameter int AW     = 5,
  parameter int MD_LAT = 32,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [AW-1:0]    rs_d,
  input  logic [AW-1:0]    rt_d,
  input  logic [AW-1:0]    rs_e,
  input  logic [AW-1:0]    rt_e,
  input  logic [AW-1:0]    write_reg_e,
  input  logic [AW-1:0]    write_reg_m,
  input  logic [AW-1:0]    write_reg_wb,
  input  logic             reg_write_e,
  input  logic             reg_write_m,
  input  logic             reg_write_wb,
  input  logic             mem_read_e,
  input  logic             mem_read_m,
  input  logic             branch_d,
  input  logic             jump_reg_d,
  input  logic             muldiv_d,
  input  logic             hilo_read_d,
  input  logic             muldiv_start_e,
  input  logic             stat_clear,
  output logic             stall_f,
  output logic             stall_d,
  output logic             flush_e,
  output logic             forward_a_d,
  output logic             forward_b_d,
  output logic [1:0]       forward_a_e,
  output logic [1:0]       forward_b_e,
  output logic             muldiv_busy,
  output logic [CNT_W-1:0] stall_count,
  output logic [2:0]       last_cause
);

  localparam logic [7:0] MD_RELOAD = 8'(MD_LAT - 1);

  logic             load_stall;
  logic             branch_stall;
  logic             md_stall;
  logic             any_stall;
  logic             reg_branch_d;
  logic [7:0]       md_cnt_q, md_cnt_d;
  logic [CNT_W-1:0] stall_count_q, stall_count_d;
  logic [2:0]       last_cause_q, last_cause_d;

  // E-stage operand selects: M result wins over WB, and register 0 is never forwarded.
  always_comb begin
    forward_a_e = 2'b00;
    forward_b_e = 2'b00;
    if (rs_e != '0 && rs_e == write_reg_m && reg_write_m)
      forward_a_e = 2'b10;
    else if (rs_e != '0 && rs_e == write_reg_wb && reg_write_wb)
      forward_a_e = 2'b01;
    if (rt_e != '0 && rt_e == write_reg_m && reg_write_m)
      forward_b_e = 2'b10;
    else if (rt_e != '0 && rt_e == write_reg_wb && reg_write_wb)
      forward_b_e = 2'b01;
  end

  // D-stage forwarding of an M-stage ALU result. A load in M has no data yet.
  always_comb begin
    forward_a_d = (rs_d != '0) && (rs_d == write_reg_m) && reg_write_m && !mem_read_m;
    forward_b_d = (rt_d != '0) && (rt_d == write_reg_m) && reg_write_m && !mem_read_m;
  end

  // Hazard detection. Each cause is kept separate so it can be recorded.
  always_comb begin
    reg_branch_d = branch_d | jump_reg_d;
    load_stall   = mem_read_e && (write_reg_e != '0) &&
                   ((write_reg_e == rs_d) || (write_reg_e == rt_d));
    branch_stall = (reg_branch_d && reg_write_e && (write_reg_e != '0) &&
                    ((write_reg_e == rs_d) || (write_reg_e == rt_d))) ||
                   (reg_branch_d && mem_read_m && (write_reg_m != '0) &&
                    ((write_reg_m == rs_d) || (write_reg_m == rt_d)));
    md_stall     = (muldiv_d | hilo_read_d) && (muldiv_busy | muldiv_start_e);
    any_stall    = load_stall | branch_stall | md_stall;
    stall_f      = any_stall;
    stall_d      = any_stall;
    flush_e      = any_stall;
  end

  // Mult/div busy window. A new start always reloads the counter, even while it is still counting.
  always_comb begin
    md_cnt_d = md_cnt_q;
    if (muldiv_start_e)
      md_cnt_d = MD_RELOAD;
    else if (md_cnt_q != 8'd0)
      md_cnt_d = md_cnt_q - 8'd1;
  end

  // Statistics next state. A clear takes priority over counting and over recording a cause.
  always_comb begin
    stall_count_d = stall_count_q;
    last_cause_d  = last_cause_q;
    if (stat_clear) begin
      stall_count_d = '0;
      last_cause_d  = 3'b000;
    end else if (any_stall) begin
      if (stall_count_q != {CNT_W{1'b1}})
        stall_count_d = stall_count_q + 1'b1;
      last_cause_d = {md_stall, branch_stall, load_stall};
    end
  end

  // State registers. An asynchronous reset aborts any mult/div window in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      md_cnt_q      <= 8'd0;
      stall_count_q <= '0;
      last_cause_q  <= 3'b000;
    end else begin
      md_cnt_q      <= md_cnt_d;
      stall_count_q <= stall_count_d;
      last_cause_q  <= last_cause_d;
    end
  end

  assign muldiv_busy = (md_cnt_q != 8'd0);
  assign stall_count = stall_count_q;
  assign last_cause  = last_cause_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard, built with MD_LAT=4 and CNT_W=4. A table of
// combinational vectors is followed by hand-written multi-cycle sequences.
module tb_hazard_scoreboard;

  localparam int AW     = 5;
  localparam int MD_LAT = 4;
  localparam int CNT_W  = 4;

  logic clk, rst_n;
  logic [AW-1:0] rs_d, rt_d, rs_e, rt_e, write_reg_e, write_reg_m, write_reg_wb;
  logic reg_write_e, reg_write_m, reg_write_wb, mem_read_e, mem_read_m;
  logic branch_d, jump_reg_d, muldiv_d, hilo_read_d, muldiv_start_e, stat_clear;
  logic stall_f, stall_d, flush_e, forward_a_d, forward_b_d, muldiv_busy;
  logic [1:0] forward_a_e, forward_b_e;
  logic [CNT_W-1:0] stall_count;
  logic [2:0] last_cause;

  int checks = 0;
  int errors = 0;

  hazard_scoreboard #(.AW(AW), .MD_LAT(MD_LAT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .rs_d(rs_d), .rt_d(rt_d), .rs_e(rs_e), .rt_e(rt_e),
    .write_reg_e(write_reg_e), .write_reg_m(write_reg_m), .write_reg_wb(write_reg_wb),
    .reg_write_e(reg_write_e), .reg_write_m(reg_write_m), .reg_write_wb(reg_write_wb),
    .mem_read_e(mem_read_e), .mem_read_m(mem_read_m),
    .branch_d(branch_d), .jump_reg_d(jump_reg_d),
    .muldiv_d(muldiv_d), .hilo_read_d(hilo_read_d),
    .muldiv_start_e(muldiv_start_e), .stat_clear(stat_clear),
    .stall_f(stall_f), .stall_d(stall_d), .flush_e(flush_e),
    .forward_a_d(forward_a_d), .forward_b_d(forward_b_d),
    .forward_a_e(forward_a_e), .forward_b_e(forward_b_e),
    .muldiv_busy(muldiv_busy), .stall_count(stall_count), .last_cause(last_cause)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0] rs_d, rt_d, rs_e, rt_e, wr_e, wr_m, wr_wb;
    logic rw_e, rw_m, rw_wb, mr_e, mr_m, br, jr, md_d, hilo;
    logic [1:0] fa_e, fb_e;
    logic fa_d, fb_d, stall;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic check_stall(input string name, input logic exp);
    check({name, "_stall_f"}, {31'd0, stall_f}, {31'd0, exp});
    check({name, "_stall_d"}, {31'd0, stall_d}, {31'd0, exp});
    check({name, "_flush_e"}, {31'd0, flush_e}, {31'd0, exp});
  endtask

  // Driver tasks
  task automatic idle_inputs();
    rs_d = '0; rt_d = '0; rs_e = '0; rt_e = '0;
    write_reg_e = '0; write_reg_m = '0; write_reg_wb = '0;
    reg_write_e = 1'b0; reg_write_m = 1'b0; reg_write_wb = 1'b0;
    mem_read_e = 1'b0; mem_read_m = 1'b0;
    branch_d = 1'b0; jump_reg_d = 1'b0; muldiv_d = 1'b0; hilo_read_d = 1'b0;
    muldiv_start_e = 1'b0; stat_clear = 1'b0;
  endtask

  task automatic apply_vec(input vec_t v);
    rs_d = v.rs_d; rt_d = v.rt_d; rs_e = v.rs_e; rt_e = v.rt_e;
    write_reg_e = v.wr_e; write_reg_m = v.wr_m; write_reg_wb = v.wr_wb;
    reg_write_e = v.rw_e; reg_write_m = v.rw_m; reg_write_wb = v.rw_wb;
    mem_read_e = v.mr_e; mem_read_m = v.mr_m;
    branch_d = v.br; jump_reg_d = v.jr; muldiv_d = v.md_d; hilo_read_d = v.hilo;
    muldiv_start_e = 1'b0; stat_clear = 1'b0;
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic load_use();
    idle_inputs();
    mem_read_e = 1'b1; write_reg_e = 5'd8; rt_d = 5'd8;
  endtask

  task automatic clear_stats();
    idle_inputs();
    stat_clear = 1'b1;
    next_cyc();
    idle_inputs();
  endtask

  initial begin
    logic [CNT_W-1:0] exp_cnt;
    //               rs_d  rt_d  rs_e  rt_e  wr_e  wr_m  wr_wb rwe   rwm   rwwb  mre   mrm   br    jr    mdd   hilo  fa_e   fb_e   fa_d  fb_d  stall
    vecs[0]  = '{5'd0, 5'd0, 5'd5, 5'd0, 5'd0, 5'd5, 5'd5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{5'd0, 5'd0, 5'd5, 5'd0, 5'd0, 5'd5, 5'd5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd5, 5'd5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{5'd0, 5'd0, 5'd3, 5'd7, 5'd0, 5'd3, 5'd7, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b01, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{5'd4, 5'd6, 5'd0, 5'd0, 5'd0, 5'd6, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0};
    vecs[5]  = '{5'd4, 5'd6, 5'd0, 5'd0, 5'd0, 5'd6, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{5'd0, 5'd8, 5'd0, 5'd0, 5'd8, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1};
    vecs[7]  = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{5'd9, 5'd0, 5'd0, 5'd0, 5'd9, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1};
    vecs[9]  = '{5'd9, 5'd0, 5'd0, 5'd0, 5'd9, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{5'd3, 5'd0, 5'd0, 5'd0, 5'd0, 5'd3, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1};
    vecs[11] = '{5'd3, 5'd0, 5'd0, 5'd0, 5'd0, 5'd3, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0};
    vecs[12] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0};
    vecs[14] = '{5'd0, 5'd12,5'd0, 5'd0, 5'd12,5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1};

    // Reset state; combinational outputs stay live during reset
    idle_inputs();
    rst_n = 1'b0;
    next_cyc();
    check("rst_busy", {31'd0, muldiv_busy}, 32'd0);
    check("rst_count", {28'd0, stall_count}, 32'd0);
    check("rst_cause", {29'd0, last_cause}, 32'd0);
    load_use();
    #1;
    check_stall("rst_comb", 1'b1);
    next_cyc();
    check("rst_count_held", {28'd0, stall_count}, 32'd0);
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    next_cyc();

    // Table of combinational vectors
    for (int i = 0; i < 15; i++) begin
      apply_vec(vecs[i]);
      @(negedge clk);
      check($sformatf("vec%0d_fa_e", i), {30'd0, forward_a_e}, {30'd0, vecs[i].fa_e});
      check($sformatf("vec%0d_fb_e", i), {30'd0, forward_b_e}, {30'd0, vecs[i].fb_e});
      check($sformatf("vec%0d_fa_d", i), {31'd0, forward_a_d}, {31'd0, vecs[i].fa_d});
      check($sformatf("vec%0d_fb_d", i), {31'd0, forward_b_d}, {31'd0, vecs[i].fb_d});
      check_stall($sformatf("vec%0d", i), vecs[i].stall);
      next_cyc();
    end

    // Load-use: one stall cycle, then the load sits in M and decode proceeds
    clear_stats();
    check("clr_count", {28'd0, stall_count}, 32'd0);
    check("clr_cause", {29'd0, last_cause}, 32'd0);
    load_use();
    @(negedge clk);
    check_stall("lu_c0", 1'b1);
    next_cyc();
    idle_inputs();
    mem_read_m = 1'b1; reg_write_m = 1'b1; write_reg_m = 5'd8; rt_d = 5'd8;
    @(negedge clk);
    check_stall("lu_c1", 1'b0);
    check("lu_count", {28'd0, stall_count}, 32'd1);
    check("lu_cause", {29'd0, last_cause}, 32'd1);
    next_cyc();

    // Mult/div: start pulse with mfhi held in decode
    clear_stats();
    for (int i = 0; i < 5; i++) begin
      idle_inputs();
      hilo_read_d = 1'b1;
      muldiv_start_e = (i == 0);
      @(negedge clk);
      check_stall($sformatf("md_c%0d", i), i < 4);
      check($sformatf("md_busy_c%0d", i), {31'd0, muldiv_busy}, {31'd0, (i >= 1 && i <= 3)});
      next_cyc();
    end
    check("md_count", {28'd0, stall_count}, 32'd4);
    check("md_cause", {29'd0, last_cause}, 32'd4);

    // Branch against a load in M, then against an ALU result in M
    idle_inputs();
    branch_d = 1'b1; rs_d = 5'd3; mem_read_m = 1'b1; reg_write_m = 1'b1; write_reg_m = 5'd3;
    @(negedge clk);
    check_stall("br_c0", 1'b1);
    check("br_c0_fa_d", {31'd0, forward_a_d}, 32'd0);
    next_cyc();
    mem_read_m = 1'b0;
    @(negedge clk);
    check_stall("br_c1", 1'b0);
    check("br_c1_fa_d", {31'd0, forward_a_d}, 32'd1);
    check("br_cause", {29'd0, last_cause}, 32'd2);
    next_cyc();

    // Stall counter saturation and clear during a stall
    clear_stats();
    exp_cnt = '0;
    for (int i = 0; i < 20; i++) begin
      load_use();
      @(negedge clk);
      check($sformatf("sat_c%0d", i), {28'd0, stall_count}, {28'd0, exp_cnt});
      if (exp_cnt != {CNT_W{1'b1}}) exp_cnt = exp_cnt + 1'b1;
      next_cyc();
    end
    load_use();
    stat_clear = 1'b1;
    next_cyc();
    load_use();
    @(negedge clk);
    check("sat_clr0", {28'd0, stall_count}, 32'd0);
    check("sat_clr_cause", {29'd0, last_cause}, 32'd0);
    next_cyc();
    @(negedge clk);
    check("sat_clr1", {28'd0, stall_count}, 32'd1);
    next_cyc();

    // Asynchronous reset in the middle of a mult/div window
    clear_stats();
    hilo_read_d = 1'b1; muldiv_start_e = 1'b1;
    next_cyc();
    muldiv_start_e = 1'b0;
    next_cyc();
    check("ar_busy_pre", {31'd0, muldiv_busy}, 32'd1);
    check("ar_count_pre", {28'd0, stall_count}, 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_busy", {31'd0, muldiv_busy}, 32'd0);
    check("ar_count", {28'd0, stall_count}, 32'd0);
    check("ar_cause", {29'd0, last_cause}, 32'd0);
    check_stall("ar_comb", 1'b0);
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b1;
    next_cyc();
    check("ar_busy_post", {31'd0, muldiv_busy}, 32'd0);

    // Restart while busy reloads the full latency
    idle_inputs();
    muldiv_start_e = 1'b1;
    next_cyc();
    muldiv_start_e = 1'b0;
    next_cyc();
    muldiv_start_e = 1'b1;
    next_cyc();
    idle_inputs();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("rs_busy_c%0d", i), {31'd0, muldiv_busy}, {31'd0, (i < 3)});
      next_cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
